// File: rtl/zclock_gen.sv
// CPU clock generator for the Z80 core: derives a 3.5/7/14 MHz zclk level plus
// zpos/zneg edge strobes from the 28 MHz quarter-phase strobes c0..c3.
module zclock_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       c0,
  input  logic       c1,
  input  logic       c2,
  input  logic       c3,
  input  logic [1:0] turbo,
  input  logic       zwait,
  output logic       zclk,
  output logic       zpos,
  output logic       zneg,
  output logic [1:0] turbo_cur,
  output logic       sw_pend
);

  localparam logic [1:0] RATE_3M5 = 2'b00;
  localparam logic [1:0] RATE_7M  = 2'b01;
  localparam logic [1:0] RATE_14M = 2'b10;

  logic       p;
  logic       boundary;
  logic [1:0] turbo_norm;
  logic       pos_strobe;
  logic       neg_strobe;

  // p marks the second half of the 8-cycle frame; c3 with p set closes the frame.
  assign boundary   = c3 & p;
  assign turbo_norm = turbo[1] ? RATE_14M : turbo;
  assign sw_pend    = (turbo_norm != turbo_cur);

  always_comb begin
    // NOTE: defaults first so every path assigns both strobes; no latch is inferred.
    pos_strobe = 1'b0;
    neg_strobe = 1'b0;
    case (turbo_cur)
      RATE_14M: begin
        pos_strobe = c0 | c2;
        neg_strobe = c1 | c3;
      end
      RATE_7M: begin
        pos_strobe = c0;
        neg_strobe = c2;
      end
      RATE_3M5: begin
        pos_strobe = c0 & ~p;
        neg_strobe = c0 & p;
      end
      default: begin
        pos_strobe = 1'b0;
        neg_strobe = 1'b0;
      end
    endcase
  end

  // Rate changes only at the frame boundary, where every rate has just issued
  // its falling edge, so no runt phase can appear across a switch.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      p         <= 1'b0;
      turbo_cur <= RATE_3M5;
    end else begin
      p <= p ^ c3;
      if (boundary) turbo_cur <= turbo_norm;
    end
  end

  // A pos strobe suppressed by zwait is dropped; falling edges are never blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zpos <= 1'b0;
      zneg <= 1'b0;
      zclk <= 1'b0;
    end else begin
      zpos <= pos_strobe & ~zwait;
      zneg <= neg_strobe;
      if (zneg)      zclk <= 1'b0;
      else if (zpos) zclk <= 1'b1;
    end
  end

endmodule
